// File: rtl/slave_port_v3.sv
// Bit-serial memory-mapped bus slave: MSB-first address/data frames, range-checked word memory.
// Optional even-parity on write data and read beats is built when SLAVE_PORT_PARITY_EN is defined.
module slave_port_v3 #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 8,
    parameter int          MEM_DEPTH  = 64,
    parameter int unsigned BASE_ADDR  = 32'h0100
) (
    input  logic clk,
    input  logic rst,
    input  logic mode,
    input  logic wr_bus,
    input  logic master_valid,
    input  logic master_ready,
    output logic rd_bus,
    output logic slave_ready,
    output logic slave_valid,
    output logic slave_err
);

`ifdef SLAVE_PORT_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int SH_W  = DATA_WIDTH + PAR_W;
    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 2);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [ADDR_WIDTH:0] BASE_EXT  = (ADDR_WIDTH + 1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]    LAST_A    = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]    LAST_D    = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]    LAST_S    = CNT_W'(SH_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
`ifdef SLAVE_PORT_PARITY_EN
        S_WPAR,
`endif
        S_WRITE,
        S_READ,
        S_SEND
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [SH_W-1:0]        shift_q, shift_d;
    logic                   slave_ready_q, slave_ready_d;
    logic                   slave_valid_q, slave_valid_d;
    logic                   slave_err_q, slave_err_d;
    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    // Subtraction is one bit wider than the address so addresses below the base never wrap into range.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] diff;
        diff = {1'b0, a} - BASE_EXT;
        return ({1'b0, a} >= BASE_EXT) && (diff < DEPTH_EXT);
    endfunction

    function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] diff;
        diff = {1'b0, a} - BASE_EXT;
        return IDX_W'(diff);
    endfunction

    function automatic logic [SH_W-1:0] load_word(input logic [DATA_WIDTH-1:0] w);
`ifdef SLAVE_PORT_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        shift_d     = shift_q;
        slave_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (master_valid) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (!master_valid) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    addr_d = {addr_q[ADDR_WIDTH-2:0], wr_bus};
                    if (cnt_q == LAST_A) begin
                        cnt_d = '0;
                        if (mode) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d     = S_READ;
                            slave_err_d = !in_range(addr_d);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WDATA: begin
                if (!master_valid) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    shift_d = {shift_q[SH_W-2:0], wr_bus};
                    if (cnt_q == LAST_D) begin
                        cnt_d = '0;
`ifdef SLAVE_PORT_PARITY_EN
                        state_d = S_WPAR;
`else
                        state_d     = S_WRITE;
                        slave_err_d = !in_range(addr_q);
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef SLAVE_PORT_PARITY_EN
            S_WPAR: begin
                cnt_d = '0;
                if (!master_valid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_WRITE;
                    slave_err_d = !in_range(addr_q) || (wr_bus != ^shift_q[DATA_WIDTH-1:0]);
                end
            end
`endif
            S_WRITE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            // slave_err_q was set on entry to READ exactly when the address is out of range.
            S_READ: begin
                cnt_d = '0;
                if (slave_err_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SEND;
                    shift_d = load_word(mem[mem_idx(addr_q)]);
                end
            end
            S_SEND: begin
                if (master_ready) begin
                    shift_d = {shift_q[SH_W-2:0], 1'b0};
                    if (cnt_q == LAST_S) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        slave_ready_d = (state_d == S_ADDR) || (state_d == S_WDATA)
`ifdef SLAVE_PORT_PARITY_EN
                        || (state_d == S_WPAR)
`endif
                        ;
        slave_valid_d = (state_d == S_SEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            shift_q       <= '0;
            slave_ready_q <= 1'b0;
            slave_valid_q <= 1'b0;
            slave_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            shift_q       <= shift_d;
            slave_ready_q <= slave_ready_d;
            slave_valid_q <= slave_valid_d;
            slave_err_q   <= slave_err_d;
        end
    end

    // A WRITE cycle flagged with an error (range or parity) leaves memory untouched.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_WRITE && !slave_err_q)
            mem[mem_idx(addr_q)] <= shift_q[DATA_WIDTH-1:0];
    end

    assign slave_ready = slave_ready_q;
    assign slave_valid = slave_valid_q;
    assign slave_err   = slave_err_q;
    assign rd_bus      = slave_valid_q & shift_q[SH_W-1];

endmodule
